// File: rtl/isa_pkg.sv
// Shared ISA/fetch definitions: datapath widths, reset PC, sequential increment,
// the halt opcode, the fetch FSM state encoding and the IF/ID payload bundle.
package isa_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam logic [ADDR_W-1:0] PC_INC   = 16'h0002;
    localparam logic [3:0]        OPC_HALT = 4'hF;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

    // Contents of the IF/ID boundary register.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus;
    } if_payload_t;

endpackage

// File: rtl/adder_pc.sv
// 16-bit carry-lookahead adder used for PC arithmetic.
// Four 4-bit groups: group generate/propagate feed the group carries, and each
// group resolves its internal carries from its own group carry-in.
// Ports:
//   A   in  ADDR_W  first operand
//   B   in  ADDR_W  second operand
//   Sub in  1       1: A - B (two's complement), 0: A + B
//   Sum out ADDR_W  result, modulo 2^ADDR_W (carry-out discarded)
module adder_pc
    import isa_pkg::*;
(
    input  logic [ADDR_W-1:0] A,
    input  logic [ADDR_W-1:0] B,
    input  logic              Sub,
    output logic [ADDR_W-1:0] Sum
);

    localparam int unsigned GRP_W = 4;
    localparam int unsigned N_GRP = ADDR_W / GRP_W;

    logic [ADDR_W-1:0] w_b;
    logic [ADDR_W-1:0] w_g;
    logic [ADDR_W-1:0] w_p;
    logic [ADDR_W-1:0] w_c;
    // The top group's generate/propagate would only feed the discarded carry-out.
    logic [N_GRP-2:0]  w_gg;
    logic [N_GRP-2:0]  w_gp;
    logic [N_GRP-1:0]  w_gc;

    // Bit-level generate/propagate, group lookahead, then in-group carries.
    always_comb begin
        w_b = B ^ {ADDR_W{Sub}};
        w_g = A & w_b;
        w_p = A ^ w_b;

        for (int k = 0; k < int'(N_GRP) - 1; k++) begin
            w_gg[k] = w_g[k*4+3]
                    | (w_p[k*4+3] & w_g[k*4+2])
                    | (w_p[k*4+3] & w_p[k*4+2] & w_g[k*4+1])
                    | (w_p[k*4+3] & w_p[k*4+2] & w_p[k*4+1] & w_g[k*4]);
            w_gp[k] = &w_p[k*4 +: 4];
        end

        w_gc[0] = Sub;
        for (int k = 1; k < int'(N_GRP); k++) begin
            w_gc[k] = w_gg[k-1] | (w_gp[k-1] & w_gc[k-1]);
        end

        for (int i = 0; i < int'(ADDR_W); i++) begin
            if ((i % int'(GRP_W)) == 0) begin
                w_c[i] = w_gc[i / int'(GRP_W)];
            end else begin
                w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
            end
        end

        Sum = w_p ^ w_c;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// registers the fetched instruction into the IF/ID boundary.
// Priority each cycle: branch redirect > stall > accept > bubble.
// Optional feature macro: HALT_DETECT_EN (halt opcode detection, HALT state).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               hold IF/ID and PC
//   branch_taken/target redirect the PC, flush IF/ID
//   imem_req/addr       read request; addr is the PC register
//   imem_ready/rdata    read data valid for imem_addr this cycle
//   if_valid/instr/pc/pc_plus  IF/ID boundary outputs
//   halted              halt reached (constant 0 without HALT_DETECT_EN)
module pc_fetch_unit #(
    parameter logic [isa_pkg::ADDR_W-1:0] RESET_PC = isa_pkg::RESET_PC,
    parameter logic [isa_pkg::ADDR_W-1:0] PC_INC   = isa_pkg::PC_INC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [isa_pkg::ADDR_W-1:0]   branch_target,
    output logic                         imem_req,
    output logic [isa_pkg::ADDR_W-1:0]   imem_addr,
    input  logic                         imem_ready,
    input  logic [isa_pkg::INSTR_W-1:0]  imem_rdata,
    output logic                         if_valid,
    output logic [isa_pkg::INSTR_W-1:0]  if_instr,
    output logic [isa_pkg::ADDR_W-1:0]   if_pc,
    output logic [isa_pkg::ADDR_W-1:0]   if_pc_plus,
    output logic                         halted
);

    import isa_pkg::*;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nx;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nx;
    logic [ADDR_W-1:0] w_pc_next;
    logic              r_req;
    logic              w_req_nx;
    logic              r_valid;
    logic              w_valid_nx;
    if_payload_t       r_if;
    if_payload_t       w_if_nx;
    logic              w_accept;
`ifdef HALT_DETECT_EN
    logic              r_halted;
    logic              w_halted_nx;
`endif

    // Sequential PC increment.
    adder_pc u_adder_pc (
        .A   (r_pc),
        .B   (PC_INC),
        .Sub (1'b0),
        .Sum (w_pc_next)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_valid  <= 1'b0;
            r_if     <= '0;
`ifdef HALT_DETECT_EN
            r_halted <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_req    <= w_req_nx;
            r_valid  <= w_valid_nx;
            r_if     <= w_if_nx;
`ifdef HALT_DETECT_EN
            r_halted <= w_halted_nx;
`endif
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_req_nx    = r_req;
        w_valid_nx  = r_valid;
        w_if_nx     = r_if;
`ifdef HALT_DETECT_EN
        w_halted_nx = r_halted;
`endif
        w_accept    = r_req & imem_ready & ~stall & ~branch_taken;

        case (r_state)
            FETCH: begin
                w_req_nx = 1'b1;
                if (branch_taken) begin
                    // Flush: anything returned this cycle belonged to the old path.
                    w_pc_nx    = branch_target;
                    w_valid_nx = 1'b0;
                end else if (!stall) begin
                    if (w_accept) begin
                        w_if_nx.instr   = imem_rdata;
                        w_if_nx.pc      = r_pc;
                        w_if_nx.pc_plus = w_pc_next;
                        w_valid_nx      = 1'b1;
                        w_pc_nx         = w_pc_next;
`ifdef HALT_DETECT_EN
                        // Halt instruction still goes to IF/ID; PC parks on it.
                        if (imem_rdata[INSTR_W-1 -: 4] == OPC_HALT) begin
                            w_pc_nx     = r_pc;
                            w_state_nx  = HALT;
                            w_req_nx    = 1'b0;
                            w_halted_nx = 1'b1;
                        end
`endif
                    end else begin
                        w_valid_nx = 1'b0;
                    end
                end
            end
            HALT: begin
                w_req_nx   = 1'b0;
                w_valid_nx = 1'b0;
`ifdef HALT_DETECT_EN
                w_halted_nx = 1'b1;
`endif
            end
            default: begin
                w_state_nx = FETCH;
            end
        endcase
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign if_valid   = r_valid;
    assign if_instr   = r_if.instr;
    assign if_pc      = r_if.pc;
    assign if_pc_plus = r_if.pc_plus;
`ifdef HALT_DETECT_EN
    assign halted     = r_halted;
`else
    assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
`timescale 1ns/1ps
module tb_pc_fetch_unit;
    import isa_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus;
    logic        halted;
    logic        plant_halt;

    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_rdata;
    logic        wr_valid;
    logic [15:0] wr_instr;
    logic [15:0] wr_pc;
    logic [15:0] wr_pc_plus;
    logic        wr_halted;

    int n_checks = 0;
    int n_errors = 0;

    if_payload_t sb[$];
    logic [15:0] m_pc;
    logic        m_req;
    logic        m_valid;
    logic        m_halted;
    if_payload_t m_last;

    // Memory image: address-derived words, optional halt word at 0x0006.
    function automatic logic [15:0] mem_word(input logic [15:0] a, input logic ph);
        if (ph && a == 16'h0006) return 16'hF000;
        return {4'h3, a[11:0] ^ 12'hA50};
    endfunction

    assign imem_rdata = mem_word(imem_addr, plant_halt);
    assign wr_rdata   = mem_word(wr_addr, 1'b0);

    pc_fetch_unit u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus    (if_pc_plus),
        .halted        (halted)
    );

    pc_fetch_unit #(.RESET_PC(16'hFFFC)) u_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (16'h0000),
        .imem_req      (wr_req),
        .imem_addr     (wr_addr),
        .imem_ready    (1'b1),
        .imem_rdata    (wr_rdata),
        .if_valid      (wr_valid),
        .if_instr      (wr_instr),
        .if_pc         (wr_pc),
        .if_pc_plus    (wr_pc_plus),
        .halted        (wr_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic assert_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
        imem_ready = 1'b0;
        m_pc = 16'h0000;
        m_req = 1'b0;
        m_valid = 1'b0;
        m_halted = 1'b0;
        m_last = '0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock of stimulus; model update, scoreboard push on expected accept,
    // pop and compare when the DUT registers the instruction.
    task automatic drive_cycle(input logic rdy, input logic stl, input logic br,
                               input logic [15:0] tgt);
        logic        acc;
        logic        is_halt;
        if_payload_t exp_e;
        if_payload_t got;
        imem_ready = rdy;
        stall = stl;
        branch_taken = br;
        branch_target = tgt;
        acc = m_req && rdy && !stl && !br;
        exp_e = '0;
        if (m_halted) begin
            m_valid = 1'b0;
        end else if (br) begin
            m_pc = tgt;
            m_valid = 1'b0;
        end else if (!stl) begin
            if (acc) begin
                exp_e.instr = mem_word(m_pc, plant_halt);
                exp_e.pc = m_pc;
                exp_e.pc_plus = m_pc + 16'h0002;
                sb.push_back(exp_e);
                m_valid = 1'b1;
`ifdef HALT_DETECT_EN
                is_halt = (exp_e.instr[15:12] == 4'hF);
`else
                is_halt = 1'b0;
`endif
                if (is_halt) m_halted = 1'b1;
                else m_pc = m_pc + 16'h0002;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_req = !m_halted;
        @(posedge clk);
        #1;
        n_checks++;
        if (if_valid !== m_valid) begin
            n_errors++;
            $display("FAIL if_valid: got %b expected %b (model pc %h)", if_valid, m_valid, m_pc);
        end
        n_checks++;
        if (imem_req !== m_req) begin
            n_errors++;
            $display("FAIL imem_req: got %b expected %b", imem_req, m_req);
        end
        if (acc) begin
            got = sb.pop_front();
            m_last = got;
        end
        if (m_valid) begin
            n_checks++;
            if (if_instr !== m_last.instr || if_pc !== m_last.pc || if_pc_plus !== m_last.pc_plus) begin
                n_errors++;
                $display("FAIL if_payload: got instr %h pc %h plus %h expected instr %h pc %h plus %h",
                         if_instr, if_pc, if_pc_plus, m_last.instr, m_last.pc, m_last.pc_plus);
            end
        end
    endtask

    task automatic test_reset();
        plant_halt = 1'b0;
        assert_reset();
        n_checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || halted !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got req %b valid %b halted %b expected 0 0 0", imem_req, if_valid, halted);
        end
        n_checks++;
        if (if_instr !== 16'h0 || if_pc !== 16'h0 || if_pc_plus !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_if: got %h %h %h expected 0000 0000 0000", if_instr, if_pc, if_pc_plus);
        end
        n_checks++;
        if (imem_addr !== 16'h0000 || wr_addr !== 16'hFFFC) begin
            n_errors++;
            $display("FAIL reset_pc: got %h / %h expected 0000 / fffc", imem_addr, wr_addr);
        end
        release_reset();
    endtask

    task automatic test_stream();
        logic [15:0] exp_addr [3];
        exp_addr = '{16'h0000, 16'h0002, 16'h0004};
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
            n_checks++;
            if (imem_addr !== exp_addr[i]) begin
                n_errors++;
                $display("FAIL stream_addr[%0d]: got %h expected %h", i, imem_addr, exp_addr[i]);
            end
        end
        n_checks++;
        if (if_pc !== 16'h0002 || if_pc_plus !== 16'h0004) begin
            n_errors++;
            $display("FAIL stream_pc_plus: got pc %h plus %h expected 0002 0004", if_pc, if_pc_plus);
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 16'h0000);
            n_checks++;
            if (imem_addr !== 16'h0004) begin
                n_errors++;
                $display("FAIL wait_addr[%0d]: got %h expected 0004", i, imem_addr);
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (if_pc !== 16'h0004 || imem_addr !== 16'h0006) begin
            n_errors++;
            $display("FAIL wait_release: got if_pc %h addr %h expected 0004 0006", if_pc, imem_addr);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 16'h0000);
            n_checks++;
            if (if_pc !== 16'h0004 || if_instr !== 16'h3A54 || imem_addr !== 16'h0006) begin
                n_errors++;
                $display("FAIL stall_hold[%0d]: got pc %h instr %h addr %h expected 0004 3a54 0006",
                         i, if_pc, if_instr, imem_addr);
            end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (if_pc !== 16'h0006 || imem_addr !== 16'h0008) begin
            n_errors++;
            $display("FAIL stall_release: got pc %h addr %h expected 0006 0008", if_pc, imem_addr);
        end
    endtask

    task automatic test_branch();
        drive_cycle(1'b1, 1'b1, 1'b1, 16'h0100);
        n_checks++;
        if (imem_addr !== 16'h0100) begin
            n_errors++;
            $display("FAIL branch_addr: got %h expected 0100", imem_addr);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        n_checks++;
        if (if_pc !== 16'h0100 || if_pc_plus !== 16'h0102 || imem_addr !== 16'h0102) begin
            n_errors++;
            $display("FAIL branch_fetch: got pc %h plus %h addr %h expected 0100 0102 0102",
                     if_pc, if_pc_plus, imem_addr);
        end
        drive_cycle(1'b0, 1'b0, 1'b1, 16'h0040);
        n_checks++;
        if (imem_addr !== 16'h0040) begin
            n_errors++;
            $display("FAIL branch_wait_addr: got %h expected 0040", imem_addr);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [3];
        exp_addr = '{16'hFFFC, 16'hFFFE, 16'h0000};
        assert_reset();
        release_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
            n_checks++;
            if (wr_addr !== exp_addr[i] || wr_req !== 1'b1 || wr_halted !== 1'b0) begin
                n_errors++;
                $display("FAIL wrap_addr[%0d]: got %h req %b halted %b expected %h 1 0",
                         i, wr_addr, wr_req, wr_halted, exp_addr[i]);
            end
        end
        n_checks++;
        if (wr_valid !== 1'b1 || wr_pc !== 16'hFFFE || wr_pc_plus !== 16'h0000 || wr_instr !== 16'h35AE) begin
            n_errors++;
            $display("FAIL wrap_if: got valid %b pc %h plus %h instr %h expected 1 fffe 0000 35ae",
                     wr_valid, wr_pc, wr_pc_plus, wr_instr);
        end
    endtask

    task automatic test_halt();
        plant_halt = 1'b1;
        assert_reset();
        release_reset();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
`ifdef HALT_DETECT_EN
        n_checks++;
        if (if_instr !== 16'hF000 || halted !== 1'b1 || imem_addr !== 16'h0006) begin
            n_errors++;
            $display("FAIL halt_enter: got instr %h halted %b addr %h expected f000 1 0006",
                     if_instr, halted, imem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b1, 16'h0080);
            n_checks++;
            if (halted !== 1'b1 || imem_addr !== 16'h0006) begin
                n_errors++;
                $display("FAIL halt_hold[%0d]: got halted %b addr %h expected 1 0006", i, halted, imem_addr);
            end
        end
`else
        n_checks++;
        if (if_instr !== 16'hF000 || halted !== 1'b0 || imem_addr !== 16'h0008) begin
            n_errors++;
            $display("FAIL halt_opcode_plain: got instr %h halted %b addr %h expected f000 0 0008",
                     if_instr, halted, imem_addr);
        end
`endif
        assert_reset();
        release_reset();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        drive_cycle(1'b1, 1'b0, 1'b1, 16'h0020);
        n_checks++;
        if (halted !== 1'b0 || imem_addr !== 16'h0020) begin
            n_errors++;
            $display("FAIL halt_blocked: got halted %b addr %h expected 0 0020", halted, imem_addr);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        plant_halt = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        plant_halt = 1'b0;
        test_reset();
        test_stream();
        test_wait_states();
        test_stall();
        test_branch();
        test_wrap();
        test_halt();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
